// File: rtl/regfile_dump_reader_if.sv
// Output word stream of the register file dump reader.
// Valid/ready handshake carrying register value, index and last flag.
interface regfile_dump_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_addr,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_addr,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Register file dump sequencer: walks an address range, streams words.
// Optional XOR checksum of dumped words enabled by DUMP_CSUM_EN.
module regfile_dump_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    regfile_dump_reader_if.master out,
`ifdef DUMP_CSUM_EN
    output logic [DATA_W-1:0] csum,
`endif
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] end_addr;

    // Sequencer: every state bit and output is a register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            end_addr      <= '0;
            rd_addr       <= '0;
            out.out_data  <= '0;
            out.out_addr  <= '0;
            out.out_last  <= 1'b0;
            out.out_valid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
`ifdef DUMP_CSUM_EN
            csum          <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        rd_addr  <= first_addr;
                        end_addr <= last_addr;
                        busy     <= 1'b1;
`ifdef DUMP_CSUM_EN
                        csum     <= '0;
`endif
                        state    <= S_READ;
                    end
                end
                S_READ: begin
                    out.out_data  <= rd_data;
                    out.out_addr  <= rd_addr;
                    out.out_last  <= (rd_addr == end_addr);
                    out.out_valid <= 1'b1;
                    state         <= S_HOLD;
                end
                S_HOLD: begin
                    if (out.out_ready) begin
                        out.out_valid <= 1'b0;
`ifdef DUMP_CSUM_EN
                        csum <= csum ^ out.out_data;
`endif
                        if (out.out_last) begin
                            state <= S_DONE;
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                            state   <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a register file model.
// Checks ordering, stalls, wrap, latency, done/busy and async reset.
module tb_regfile_dump_reader;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] first_addr = '0;
    logic [AW-1:0] last_addr = '0;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
`ifdef DUMP_CSUM_EN
    logic [DW-1:0] csum;
`endif

    logic [DW-1:0] rf [32];

    int errors = 0;
    int checks = 0;

    regfile_dump_reader_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();

    assign rd_data = rf[rd_addr];

    regfile_dump_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out        (ifc.master),
`ifdef DUMP_CSUM_EN
        .csum       (csum),
`endif
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_dump(input logic [AW-1:0] f, input logic [AW-1:0] l,
                            input bit rnd, input bit poke);
        int            n;
        int            idx;
        int            cyc;
        int            dcnt;
        bit            stalled;
        logic [DW-1:0] hd;
        logic [AW-1:0] ha;
        logic [AW-1:0] ea;
        logic [AW-1:0] span;
        span = l - f;
        n = int'(span) + 1;
        idx = 0;
        cyc = 0;
        ea = f;
        stalled = 1'b0;
        hd = '0;
        ha = '0;
        @(negedge clk);
        first_addr = f;
        last_addr = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        first_addr = ~f;
        last_addr = ~l;
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("valid_one_edge", 32'(ifc.out_valid), 32'd0);
        @(negedge clk);
        chk("valid_two_edges", 32'(ifc.out_valid), 32'd1);
        while (idx < n && cyc < 600) begin
            if (stalled) begin
                chk("stall_valid", 32'(ifc.out_valid), 32'd1);
                chk("stall_data", ifc.out_data, hd);
                chk("stall_addr", 32'(ifc.out_addr), 32'(ha));
            end
            ifc.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ifc.out_valid && ifc.out_ready) begin
                chk("word_addr", 32'(ifc.out_addr), 32'(ea));
                chk("word_data", ifc.out_data, rf[ea]);
                chk("word_last", 32'(ifc.out_last), 32'(idx == n - 1));
                idx++;
                ea = ea + 1'b1;
            end
            stalled = ifc.out_valid && !ifc.out_ready;
            hd = ifc.out_data;
            ha = ifc.out_addr;
            if (poke) begin
                start = 1'($urandom_range(0, 1));
                first_addr = AW'($urandom_range(0, 31));
                last_addr = AW'($urandom_range(0, 31));
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        ifc.out_ready = 1'b1;
        chk("word_count", 32'(idx), 32'(n));
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) dcnt++;
            if (i > 0) chk("no_extra_word", 32'(ifc.out_valid), 32'd0);
            @(negedge clk);
        end
        chk("done_once", 32'(dcnt), 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int hs;
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 32; i++) rf[i] = 32'hA5C30000 + 32'(i * 32'h01010101);
        rf[1] = 32'h0F0F0F0F;
        rf[2] = 32'hFF00FF00;
        rf[5] = 32'hDEADBEEF;

        #12;
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_out_data", ifc.out_data, 32'd0);
        chk("rst_out_addr", 32'(ifc.out_addr), 32'd0);
        chk("rst_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst_last", 32'(ifc.out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
`ifdef DUMP_CSUM_EN
        chk("rst_csum", csum, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;

        run_dump(5'd0, 5'd31, 1'b0, 1'b0);
        run_dump(5'd5, 5'd5, 1'b0, 1'b0);
        run_dump(5'd30, 5'd1, 1'b0, 1'b0);
        run_dump(5'd7, 5'd20, 1'b1, 1'b1);
        run_dump(5'd31, 5'd31, 1'b1, 1'b0);

        run_dump(5'd1, 5'd2, 1'b1, 1'b0);
`ifdef DUMP_CSUM_EN
        chk("csum_1_2", csum, 32'hF00FF00F);
`endif

        @(negedge clk);
        first_addr = 5'd0;
        last_addr = 5'd31;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ifc.out_ready = 1'b1;
        hs = 0;
        for (int i = 0; i < 40 && hs < 3; i++) begin
            if (ifc.out_valid && ifc.out_ready) hs++;
            @(negedge clk);
        end
        chk("pre_reset_words", 32'(hs), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        chk("async_valid", 32'(ifc.out_valid), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_rd_addr", 32'(rd_addr), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_dump(5'd12, 5'd14, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
